stl_dispatcher: RTL
===================

# stl_dispatcher

1:N stream dispatcher: one valid/ready input stream is routed beat by beat to one of OUT_N output streams, each backed by a small per-output FIFO. Routing is either by explicit destination index or by round-robin over outputs that have space, with optional packet lock. It is the fan-out counterpart of the N:1 arbiter in the Common library and sits between a shared producer and replicated consumers.

## Interface
- OUT_N, 4, number of output streams (>=2)
- DAT_W, 16, beat data width
- DEPTH, 2, entries per output FIFO (>=1; 2 required for full per-output throughput)
- TYPE, 0, 0: route by in_dst_i; 1: round-robin over non-full outputs
- KEEP_EN, 0, 1 enables packet lock via in_keep
- OUT_NW (local), $clog2(OUT_N)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_keep  in  1  beat is not the last of a packet; next beat goes to the same output (KEEP_EN=1 only, ignored otherwise)
- in_vld_i  in  1  input beat valid
- in_dat_i  in  DAT_W  input beat data
- in_dst_i  in  OUT_NW  destination index (TYPE=0 only)
- in_rdy_o  out  1  input ready
- out_vld_o  out  OUT_N  per-output valid
- out_dat_o  out  OUT_N x DAT_W  per-output data (FIFO head)
- out_rdy_i  in  OUT_N  per-output ready
- drop_o  out  1  one-cycle pulse: a beat with in_dst_i >= OUT_N was consumed and discarded

## Operation
- Accept = in_vld_i && in_rdy_o. Pop[k] = out_vld_o[k] && out_rdy_i[k].
- Per-output FIFO: count 0..DEPTH; full[k] = (count==DEPTH); out_vld_o[k] = (count!=0); out_dat_o[k] = head entry. Strict per-output order.
- Selection sel:
  - Lock active (KEEP_EN=1, lck_vld=1): sel = lck_id.
  - Else TYPE=0: sel = in_dst_i.
  - Else TYPE=1: first index k scanning ptr, ptr+1, ... OUT_N-1, 0, ... ptr-1 with !full[k].
- in_rdy_o:
  - Lock active: !full[lck_id].
  - TYPE=0: in_dst_i >= OUT_N -> 1 (beat dropped); else !full[in_dst_i].
  - TYPE=1: any !full[k].
- in_rdy_o never depends on out_rdy_i (no combinational ready path); a pop in the same cycle does not free space for an accept until the next cycle.
- On accept to legal sel: push in_dat_i into FIFO[sel].
- Lock (KEEP_EN=1): on accept, lck_vld <= in_keep, lck_id <= sel. Lock overrides in_dst_i and ptr.
- RR pointer (TYPE=1): on accept with lock not being set (in_keep=0 or KEEP_EN=0), ptr <= (sel==OUT_N-1) ? 0 : sel+1. Accepts setting/holding lock do not move ptr.
- Drop: TYPE=0, no lock, in_dst_i >= OUT_N (only possible for non-power-of-2 OUT_N): beat consumed, no push, drop_o = 1 next cycle; lock not updated.

## Timing
- Reset values: out_vld_o=0, out_dat_o=0 (storage cleared), in_rdy_o=1, drop_o=0, counts=0, ptr=0, lck_vld=0.
- Latency: beat accepted in cycle t is visible on out_vld_o/out_dat_o in cycle t+1.
- Throughput: 1 beat/cycle input; per output 1 beat/cycle when DEPTH>=2 and consumer always ready; DEPTH=1 gives 1 beat/2 cycles per output.
- Simultaneous push and pop on same FIFO: count unchanged, head advances, new beat appended.
- Full FIFO with pop in same cycle: in_rdy_o for that output stays 0 this cycle, 1 next cycle.
- out_vld_o/out_dat_o hold stable while out_rdy_i low.
- Reset asserted mid-operation: all queued beats discarded, lock and ptr cleared, outputs return to reset values next edge.
- Counts and pointers wrap modulo DEPTH / OUT_N; no other wrap behaviour.

## Test plan
- Reset: hold rst 3 cycles with traffic driven -> out_vld_o=0, out_dat_o=0, in_rdy_o=1, drop_o=0 throughout and first cycle after.
- TYPE=0, OUT_N=4, DEPTH=2: send 0xA0..0xA3 to dst 2 with out_rdy_i[2]=0 -> first two accepted, in_rdy_o=0 on third; release out_rdy_i[2] -> 0xA0,0xA1,0xA2,0xA3 in order on output 2, others never valid.
- TYPE=1, all ready: 8 back-to-back beats 0..7 -> outputs 0,1,2,3,0,1,2,3 receive them, each 1 cycle after accept; with output 1 full, beats skip 1.
- KEEP_EN=1, TYPE=1: packet of 3 beats (in_keep=1,1,0) starting at ptr=0 -> all three on output 0, ptr=1 afterwards; next single beat to output 1.
- TYPE=0, OUT_N=3: in_dst_i=3, data 0x55 -> in_rdy_o=1, no out_vld_o, drop_o pulses once next cycle.
- Full FIFO with simultaneous pop: output 0 full, out_rdy_i[0]=1, in_dst_i=0 -> in_rdy_o=0 that cycle, accept next cycle, count returns to DEPTH.

Source files
------------

// File: rtl/stl_dispatcher.sv
// stl_dispatcher: 1:N stream dispatcher with a small FIFO per output.
// Beats are routed by destination index (TYPE=0) or round-robin over outputs
// with space (TYPE=1). An optional packet lock (KEEP_EN=1) pins every beat of
// a packet to the output chosen for its first beat.
module stl_dispatcher #(
    parameter int unsigned OUT_N   = 4,
    parameter int unsigned DAT_W   = 16,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TYPE    = 0,
    parameter bit          KEEP_EN = 1'b0,
    localparam int unsigned OUT_NW = $clog2(OUT_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_keep,
    input  logic                         in_vld_i,
    input  logic [DAT_W-1:0]             in_dat_i,
    input  logic [OUT_NW-1:0]            in_dst_i,
    output logic                         in_rdy_o,
    output logic [OUT_N-1:0]             out_vld_o,
    output logic [OUT_N-1:0][DAT_W-1:0]  out_dat_o,
    input  logic [OUT_N-1:0]             out_rdy_i,
    output logic                         drop_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Full flags padded to a power of two so any index value is addressable.
    localparam int unsigned SEL_N = 2 ** OUT_NW;

    logic [DAT_W-1:0]  mem_q [OUT_N][DEPTH];
    logic [CNT_W-1:0]  cnt_q [OUT_N];
    logic [PTR_W-1:0]  wr_q  [OUT_N];
    logic [PTR_W-1:0]  rd_q  [OUT_N];

    logic [SEL_N-1:0]  full;
    logic [OUT_N-1:0]  push;
    logic [OUT_N-1:0]  pop;
    logic [OUT_NW-1:0] sel;
    logic [OUT_NW-1:0] ptr_q;
    logic [OUT_NW-1:0] lck_id_q;
    logic              lck_vld_q;
    logic              legal;
    logic              accept;
    logic              drop_q;
    logic [31:0]       rr_pos;

    // Per-output status: full flags (padding entries read as full), head data.
    always_comb begin
        full = '1;
        for (int k = 0; k < int'(OUT_N); k++) begin
            full[k]      = (cnt_q[k] == CNT_W'(DEPTH));
            out_vld_o[k] = (cnt_q[k] != '0);
            out_dat_o[k] = mem_q[k][rd_q[k]];
        end
    end

    // Destination selection and input ready; never looks at out_rdy_i.
    always_comb begin
        sel      = '0;
        legal    = 1'b1;
        in_rdy_o = 1'b0;
        rr_pos   = '0;
        if (KEEP_EN && lck_vld_q) begin
            sel      = lck_id_q;
            in_rdy_o = !full[lck_id_q];
        end else if (TYPE == 0) begin
            sel = in_dst_i;
            if (32'(in_dst_i) >= OUT_N) begin
                legal    = 1'b0;
                in_rdy_o = 1'b1;
            end else begin
                in_rdy_o = !full[in_dst_i];
            end
        end else begin
            // Scan from the farthest offset down so the nearest free output wins.
            for (int i = int'(OUT_N) - 1; i >= 0; i--) begin
                rr_pos = 32'(ptr_q) + 32'(i);
                if (rr_pos >= OUT_N) begin
                    rr_pos = rr_pos - OUT_N;
                end
                if (!full[rr_pos[OUT_NW-1:0]]) begin
                    sel      = rr_pos[OUT_NW-1:0];
                    in_rdy_o = 1'b1;
                end
            end
        end
    end

    // Push/pop strobes per output.
    always_comb begin
        accept = in_vld_i && in_rdy_o;
        for (int k = 0; k < int'(OUT_N); k++) begin
            push[k] = accept && legal && (sel == OUT_NW'(k));
            pop[k]  = out_vld_o[k] && out_rdy_i[k];
        end
    end

    // Per-output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(OUT_N); k++) begin
                cnt_q[k] <= '0;
                wr_q[k]  <= '0;
                rd_q[k]  <= '0;
                for (int d = 0; d < int'(DEPTH); d++) begin
                    mem_q[k][d] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < int'(OUT_N); k++) begin
                if (push[k]) begin
                    mem_q[k][wr_q[k]] <= in_dat_i;
                    wr_q[k] <= (wr_q[k] == PTR_W'(DEPTH - 1)) ? '0 : wr_q[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_q[k] <= (rd_q[k] == PTR_W'(DEPTH - 1)) ? '0 : rd_q[k] + 1'b1;
                end
                if (push[k] && !pop[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end else if (!push[k] && pop[k]) begin
                    cnt_q[k] <= cnt_q[k] - 1'b1;
                end
            end
        end
    end

    // Packet lock, round-robin pointer and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            lck_vld_q <= 1'b0;
            lck_id_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= accept && !legal;
            if (KEEP_EN && accept && legal) begin
                lck_vld_q <= in_keep;
                lck_id_q  <= sel;
            end
            // Beats that open or continue a locked packet leave the pointer alone.
            if (TYPE == 1 && accept && !(KEEP_EN && in_keep)) begin
                ptr_q <= (sel == OUT_NW'(OUT_N - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    assign drop_o = drop_q;

endmodule
